// File: rtl/ls_rs_queue.sv
// ls_rs_queue: in-order load/store reservation-station queue.
//
// Holds up to DEPTH memory ops in a circular buffer. Pending operand tags
// are resolved by snooping NCDB result-broadcast channels, and the oldest
// op is issued to the load/store unit once its operands are present.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   flush             (only with LSQ_FLUSH_EN) clears the whole queue
//   alloc_*           allocation side, valid/ready handshake
//   cdb_valid/tag/data  packed broadcast channels, channel i at [i*W +: W]
//   iss_*             issue side, valid/ready handshake, head entry fields
//   count             current occupancy
//
// Build option: define LSQ_FLUSH_EN to add the synchronous flush input.
module ls_rs_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NCDB     = 3,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned UNLOCKED = 15,
    parameter int unsigned OP_W     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef LSQ_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic                    alloc_store,
    input  logic [OP_W-1:0]         alloc_op,
    input  logic [31:0]             alloc_imm,
    input  logic [TAG_W-1:0]        alloc_tagx,
    input  logic [TAG_W-1:0]        alloc_tagy,
    input  logic [31:0]             alloc_datax,
    input  logic [31:0]             alloc_datay,
    input  logic [TAG_W-1:0]        alloc_tagw,
    input  logic [4:0]              alloc_target,
    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*TAG_W-1:0]   cdb_tag,
    input  logic [NCDB*32-1:0]      cdb_data,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [OP_W-1:0]         iss_op,
    output logic                    iss_store,
    output logic [31:0]             iss_offset,
    output logic [31:0]             iss_datax,
    output logic [31:0]             iss_datay,
    output logic [TAG_W-1:0]        iss_tagw,
    output logic [4:0]              iss_target,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [TAG_W-1:0] UNLK = TAG_W'(UNLOCKED);

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } snoop_t;

    // Lowest-numbered matching channel wins; an UNLOCKED tag never matches.
    function automatic snoop_t snoop(
        input logic [TAG_W-1:0]      tag,
        input logic [NCDB-1:0]       v,
        input logic [NCDB*TAG_W-1:0] tags,
        input logic [NCDB*32-1:0]    data
    );
        snoop_t r;
        r.hit  = 1'b0;
        r.data = '0;
        if (tag != UNLK) begin
            for (int unsigned i = 0; i < NCDB; i++) begin
                if (!r.hit && v[i] && tags[i*TAG_W +: TAG_W] == tag) begin
                    r.hit  = 1'b1;
                    r.data = data[i*32 +: 32];
                end
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] store_q, store_d;
    logic [OP_W-1:0]  op_q     [DEPTH];
    logic [OP_W-1:0]  op_d     [DEPTH];
    logic [31:0]      imm_q    [DEPTH];
    logic [31:0]      imm_d    [DEPTH];
    logic [TAG_W-1:0] tagx_q   [DEPTH];
    logic [TAG_W-1:0] tagx_d   [DEPTH];
    logic [TAG_W-1:0] tagy_q   [DEPTH];
    logic [TAG_W-1:0] tagy_d   [DEPTH];
    logic [31:0]      datax_q  [DEPTH];
    logic [31:0]      datax_d  [DEPTH];
    logic [31:0]      datay_q  [DEPTH];
    logic [31:0]      datay_d  [DEPTH];
    logic [TAG_W-1:0] tagw_q   [DEPTH];
    logic [TAG_W-1:0] tagw_d   [DEPTH];
    logic [4:0]       target_q [DEPTH];
    logic [4:0]       target_d [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    snoop_t wx [DEPTH];
    snoop_t wy [DEPTH];
    snoop_t ax, ay;

    logic head_rdy;
    logic alloc_fire;
    logic iss_fire;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wx[i] = snoop(tagx_q[i], cdb_valid, cdb_tag, cdb_data);
            wy[i] = snoop(tagy_q[i], cdb_valid, cdb_tag, cdb_data);
        end
        ax = snoop(alloc_tagx, cdb_valid, cdb_tag, cdb_data);
        ay = snoop(alloc_tagy, cdb_valid, cdb_tag, cdb_data);
    end

    assign head_rdy   = valid_q[head_q] && (tagx_q[head_q] == UNLK) &&
                        (!store_q[head_q] || (tagy_q[head_q] == UNLK));
    assign alloc_ready = (count_q != CW'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign iss_valid   = head_rdy;
    assign iss_fire    = head_rdy && iss_ready;
    assign count       = count_q;

    // Fields are zeroed while not issuing so they read as 0 out of reset.
    assign iss_op     = head_rdy ? op_q[head_q]     : '0;
    assign iss_store  = head_rdy ? store_q[head_q]  : 1'b0;
    assign iss_offset = head_rdy ? imm_q[head_q]    : '0;
    assign iss_datax  = head_rdy ? datax_q[head_q]  : '0;
    assign iss_datay  = head_rdy ? datay_q[head_q]  : '0;
    assign iss_tagw   = head_rdy ? tagw_q[head_q]   : '0;
    assign iss_target = head_rdy ? target_q[head_q] : '0;

    always_comb begin
        valid_d  = valid_q;
        store_d  = store_q;
        op_d     = op_q;
        imm_d    = imm_q;
        tagx_d   = tagx_q;
        tagy_d   = tagy_q;
        datax_d  = datax_q;
        datay_d  = datay_q;
        tagw_d   = tagw_q;
        target_d = target_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && wx[i].hit) begin
                tagx_d[i]  = UNLK;
                datax_d[i] = wx[i].data;
            end
            if (valid_q[i] && wy[i].hit) begin
                tagy_d[i]  = UNLK;
                datay_d[i] = wy[i].data;
            end
        end

        if (iss_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        // Operands matching a same-cycle broadcast are stored already resolved.
        if (alloc_fire) begin
            valid_d[tail_q]  = 1'b1;
            store_d[tail_q]  = alloc_store;
            op_d[tail_q]     = alloc_op;
            imm_d[tail_q]    = alloc_imm;
            tagw_d[tail_q]   = alloc_tagw;
            target_d[tail_q] = alloc_target;
            tagx_d[tail_q]   = ax.hit ? UNLK : alloc_tagx;
            datax_d[tail_q]  = ax.hit ? ax.data : alloc_datax;
            if (!alloc_store) begin
                tagy_d[tail_q]  = UNLK;
                datay_d[tail_q] = alloc_datay;
            end else begin
                tagy_d[tail_q]  = ay.hit ? UNLK : alloc_tagy;
                datay_d[tail_q] = ay.hit ? ay.data : alloc_datay;
            end
            tail_d = tail_q + 1'b1;
        end

        case ({alloc_fire, iss_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

`ifdef LSQ_FLUSH_EN
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            store_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                op_q[i]     <= '0;
                imm_q[i]    <= '0;
                tagx_q[i]   <= UNLK;
                tagy_q[i]   <= UNLK;
                datax_q[i]  <= '0;
                datay_q[i]  <= '0;
                tagw_q[i]   <= UNLK;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            store_q  <= store_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            tagx_q   <= tagx_d;
            tagy_q   <= tagy_d;
            datax_q  <= datax_d;
            datay_q  <= datay_d;
            tagw_q   <= tagw_d;
            target_q <= target_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_ls_rs_queue.sv
module tb_ls_rs_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NCDB  = 3;
    localparam logic [3:0]  UNL   = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid, alloc_ready, alloc_store;
    logic [5:0]  alloc_op;
    logic [31:0] alloc_imm, alloc_datax, alloc_datay;
    logic [3:0]  alloc_tagx, alloc_tagy, alloc_tagw;
    logic [4:0]  alloc_target;
    logic [2:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [95:0] cdb_data;
    logic        iss_valid, iss_ready, iss_store;
    logic [5:0]  iss_op;
    logic [31:0] iss_offset, iss_datax, iss_datay;
    logic [3:0]  iss_tagw;
    logic [4:0]  iss_target;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ls_rs_queue #(.DEPTH(DEPTH), .NCDB(NCDB), .TAG_W(4), .UNLOCKED(15), .OP_W(6)) dut (
        .clk(clk), .rst(rst),
`ifdef LSQ_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_store(alloc_store),
        .alloc_op(alloc_op), .alloc_imm(alloc_imm), .alloc_tagx(alloc_tagx),
        .alloc_tagy(alloc_tagy), .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
        .alloc_tagw(alloc_tagw), .alloc_target(alloc_target),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_store(iss_store), .iss_offset(iss_offset), .iss_datax(iss_datax),
        .iss_datay(iss_datay), .iss_tagw(iss_tagw), .iss_target(iss_target),
        .count(count)
    );

    // Reference model: an ordered list of ops, oldest first.
    typedef struct {
        logic        st;
        logic [5:0]  op;
        logic [31:0] imm, dx, dy;
        logic [3:0]  tx, ty, tw;
        logic [4:0]  tgt;
    } ent_t;

    ent_t mq[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit ent_ready(input ent_t e);
        return (e.tx == UNL) && (!e.st || e.ty == UNL);
    endfunction

    task automatic wake(inout logic [3:0] t, inout logic [31:0] d);
        if (t != UNL) begin
            for (int ch = 0; ch < NCDB; ch++) begin
                if (cdb_valid[ch] && cdb_tag[ch*4 +: 4] == t) begin
                    t = UNL;
                    d = cdb_data[ch*32 +: 32];
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        bit   can_alloc, can_issue;
        ent_t e;
        can_alloc = (mq.size() != DEPTH);
        can_issue = (mq.size() > 0) && ent_ready(mq[0]);
        if (flush) begin
            mq.delete();
            return;
        end
        if (can_issue && iss_ready) void'(mq.pop_front());
        for (int k = 0; k < mq.size(); k++) begin
            e = mq[k];
            wake(e.tx, e.dx);
            if (e.st) wake(e.ty, e.dy);
            mq[k] = e;
        end
        if (alloc_valid && can_alloc) begin
            e.st  = alloc_store; e.op = alloc_op; e.imm = alloc_imm;
            e.tw  = alloc_tagw;  e.tgt = alloc_target;
            e.tx  = alloc_tagx;  e.dx = alloc_datax;
            e.ty  = alloc_store ? alloc_tagy : UNL;
            e.dy  = alloc_datay;
            wake(e.tx, e.dx);
            if (e.st) wake(e.ty, e.dy);
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        bit mv;
        mv = (mq.size() > 0) && ent_ready(mq[0]);
        check("count", 64'(count), 64'(mq.size()));
        check("alloc_ready", 64'(alloc_ready), 64'(mq.size() != DEPTH));
        check("iss_valid", 64'(iss_valid), 64'(mv));
        if (mv) begin
            check("iss_op", 64'(iss_op), 64'(mq[0].op));
            check("iss_store", 64'(iss_store), 64'(mq[0].st));
            check("iss_offset", 64'(iss_offset), 64'(mq[0].imm));
            check("iss_datax", 64'(iss_datax), 64'(mq[0].dx));
            if (mq[0].st) check("iss_datay", 64'(iss_datay), 64'(mq[0].dy));
            check("iss_tagw", 64'(iss_tagw), 64'(mq[0].tw));
            check("iss_target", 64'(iss_target), 64'(mq[0].tgt));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_store = 0; alloc_op = '0; alloc_imm = '0;
        alloc_tagx = UNL; alloc_tagy = UNL; alloc_datax = '0; alloc_datay = '0;
        alloc_tagw = '0; alloc_target = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        flush = 0;
    endtask

    task automatic set_alloc(input logic st, input logic [3:0] tx, input logic [31:0] dx,
                             input logic [3:0] ty, input logic [31:0] dy, input logic [31:0] imm);
        alloc_valid = 1; alloc_store = st; alloc_imm = imm;
        alloc_tagx = tx; alloc_datax = dx; alloc_tagy = ty; alloc_datay = dy;
        alloc_op = 6'($urandom); alloc_tagw = 4'($urandom); alloc_target = 5'($urandom);
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] t, input logic [31:0] d);
        cdb_valid[ch]        = 1'b1;
        cdb_tag[ch*4 +: 4]   = t;
        cdb_data[ch*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        mq.delete();
        check("rst_count", 64'(count), 64'd0);
        check("rst_iss_valid", 64'(iss_valid), 64'd0);
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_iss_fields", {iss_datax, iss_offset}, 64'd0);
        check("rst_iss_misc", 64'({iss_op, iss_store, iss_datay, iss_tagw, iss_target}), 64'd0);
        rst = 1;
    endtask

    function automatic logic [3:0] rnd_tag();
        return ($urandom_range(0, 2) == 0) ? UNL : 4'($urandom_range(0, 5));
    endfunction

    initial begin
        idle();
        iss_ready = 0;
        do_reset();

        // Ready load passes straight through.
        set_alloc(0, UNL, 32'h1000, UNL, 0, 8); tick(); idle();
        check("t1_valid", 64'(iss_valid), 64'd1);
        check("t1_datax", 64'(iss_datax), 64'h1000);
        check("t1_offset", 64'(iss_offset), 64'd8);
        check("t1_count", 64'(count), 64'd1);
        iss_ready = 1; tick(); iss_ready = 0;
        check("t1_drain", 64'({count, iss_valid}), 64'd0);

        // Store waits for two broadcasts on different channels.
        set_alloc(1, 4'd3, 0, 4'd5, 0, 4); tick(); idle();
        check("t2_wait0", 64'(iss_valid), 64'd0);
        set_cdb(1, 4'd3, 32'hAA); tick(); idle();
        check("t2_wait1", 64'(iss_valid), 64'd0);
        set_cdb(2, 4'd5, 32'hBB); tick(); idle();
        check("t2_valid", 64'(iss_valid), 64'd1);
        check("t2_datax", 64'(iss_datax), 64'hAA);
        check("t2_datay", 64'(iss_datay), 64'hBB);
        iss_ready = 1; tick(); iss_ready = 0;

        // Allocation-cycle capture.
        set_alloc(0, 4'd7, 0, UNL, 0, 0); set_cdb(0, 4'd7, 32'h55); tick(); idle();
        check("t3_valid", 64'(iss_valid), 64'd1);
        check("t3_datax", 64'(iss_datax), 64'h55);
        iss_ready = 1; tick(); iss_ready = 0;

        // Full queue refuses allocation even when issuing; order survives wrap.
        for (int k = 0; k < 4; k++) begin
            set_alloc(0, UNL, 32'(100 + k), UNL, 0, 0); tick();
        end
        idle();
        check("t4_full_count", 64'(count), 64'd4);
        check("t4_full_ready", 64'(alloc_ready), 64'd0);
        set_alloc(0, UNL, 32'd999, UNL, 0, 0); iss_ready = 1; tick(); idle(); iss_ready = 0;
        check("t4_count3", 64'(count), 64'd3);
        check("t4_head", 64'(iss_datax), 64'd101);
        set_alloc(0, UNL, 32'd104, UNL, 0, 0); tick(); idle();
        for (int k = 1; k <= 4; k++) begin
            check("t4_order", 64'(iss_datax), 64'(100 + k));
            iss_ready = 1; tick(); iss_ready = 0;
        end
        check("t4_empty", 64'(count), 64'd0);

        // Blocked head is not bypassed.
        set_alloc(0, 4'd2, 0, UNL, 0, 0); tick();
        set_alloc(0, UNL, 32'h77, UNL, 0, 0); tick(); idle();
        check("t5_blocked", 64'(iss_valid), 64'd0);
        set_cdb(0, 4'd2, 32'h22); tick(); idle();
        check("t5_head", 64'(iss_datax), 64'h22);
        iss_ready = 1; tick();
        check("t5_young", 64'(iss_datax), 64'h77);
        tick(); iss_ready = 0;
        check("t5_empty", 64'(iss_valid), 64'd0);

`ifdef LSQ_FLUSH_EN
        for (int k = 0; k < 3; k++) begin
            set_alloc(0, 4'd1, 0, UNL, 0, 0); tick();
        end
        set_alloc(0, UNL, 32'h5, UNL, 0, 0); flush = 1; tick(); idle();
        check("t6_count", 64'(count), 64'd0);
        check("t6_valid", 64'(iss_valid), 64'd0);
        check("t6_ready", 64'(alloc_ready), 64'd1);
        tick();
        check("t6_dropped", 64'(count), 64'd0);
`endif

        // Randomised traffic against the model, with a reset mid-run.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                set_alloc(1'($urandom), rnd_tag(), $urandom, rnd_tag(), $urandom, $urandom);
            for (int ch = 0; ch < NCDB; ch++)
                if ($urandom_range(0, 1) == 1) set_cdb(ch, 4'($urandom_range(0, 5)), $urandom);
            iss_ready = ($urandom_range(0, 9) < 6);
`ifdef LSQ_FLUSH_EN
            flush = ($urandom_range(0, 63) == 0);
`endif
            if (n == 1500) begin
                idle();
                do_reset();
            end else begin
                tick();
            end
        end

        // Drain: broadcast every tag so nothing stays blocked.
        idle();
        iss_ready = 1;
        for (int n = 0; n < 40; n++) begin
            cdb_valid = '0;
            set_cdb(n % NCDB, 4'(n % 6), 32'(n));
            tick();
        end
        idle();
        tick();
        check("final_empty", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ls_rs_queue.md
Name: ls_rs_queue

Overview:
- Multi-entry, parametrised successor to the single-slot load/store reservation station in the out-of-order execute stage.
- Holds up to DEPTH memory ops in program order and snoops NCDB result-broadcast channels to resolve operand tags.
- Issues the oldest op to the load/store unit once its operands are ready, using a valid/ready handshake.

Parameters:
- DEPTH, 4: entry count; power of two, >= 2.
- NCDB, 3: number of broadcast channels snooped (ALU0, ALU1, LS).
- TAG_W, 4: register-tag width.
- UNLOCKED, 15: tag value meaning "data present, no pending producer".
- OP_W, 6: op-code width, carried through opaquely.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-low.
- alloc_valid  in  1  allocator presents an op.
- alloc_ready  out  1  queue can accept (not full).
- alloc_store  in  1  1 = store (needs x and y), 0 = load (needs x only).
- alloc_op  in  OP_W  op code.
- alloc_imm  in  32  address offset.
- alloc_tagx / alloc_tagy  in  TAG_W each  operand tags.
- alloc_datax / alloc_datay  in  32 each  operand data (valid when tag == UNLOCKED).
- alloc_tagw  in  TAG_W  destination tag.
- alloc_target  in  5  destination register address.
- cdb_valid  in  NCDB  per-channel broadcast valid.
- cdb_tag  in  NCDB*TAG_W  packed tags; channel i occupies bits [i*TAG_W +: TAG_W].
- cdb_data  in  NCDB*32  packed data; channel i occupies bits [i*32 +: 32].
- iss_valid  out  1  head entry present and operand-ready.
- iss_ready  in  1  LS unit accepts.
- iss_op  out  OP_W  head entry field.
- iss_store  out  1  head entry field.
- iss_offset  out  32  head entry field.
- iss_datax / iss_datay  out  32 each  head entry fields.
- iss_tagw  out  TAG_W  head entry field.
- iss_target  out  5  head entry field.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst low, asynchronous): head = tail = count = 0; all entries invalid; every stored tag = UNLOCKED; all data fields = 0. Outputs: alloc_ready = 1, iss_valid = 0, all iss_* fields = 0.
- Storage is a circular buffer. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count distinguishes full from empty.
- alloc_ready = (count != DEPTH). It is registered-state based, with no same-cycle dependence on iss_ready.
  - When full, an allocation is refused even if an issue fires in the same cycle.
- Allocation: alloc_valid && alloc_ready at posedge writes the entry at tail, then tail++.
- Wakeup: for each valid entry and each operand whose tag != UNLOCKED, if cdb_valid[i] and cdb_tag[i] == that tag, then data <= cdb_data[i] and tag <= UNLOCKED at the edge.
  - If several channels match, the lowest index wins.
  - Loads ignore the y operand; its tag is forced to UNLOCKED on allocation.
- Allocation-cycle capture: an alloc operand tag matching a same-cycle broadcast is stored already resolved, with the broadcast data. This rule is mandatory; without it the entry deadlocks.
- Ready: entry is ready when tagx == UNLOCKED and (load or tagy == UNLOCKED).
  - A broadcast becomes visible on iss_valid one cycle later; there is no combinational CDB-to-issue path.
- Issue is strictly in order: iss_valid = head entry valid && ready. Younger ready entries never bypass a blocked head.
- iss_* fields are driven from the head entry; they are don't-care when iss_valid = 0 but must be stable while iss_valid = 1.
- Handshake: iss_valid && iss_ready at posedge invalidates the head entry, then head++.
- Simultaneous allocate and issue (not full): both happen and count is unchanged.
  - If the queue is empty, the new entry cannot issue in its allocation cycle.
- count updates as +1 on allocate, -1 on issue, 0 on both.
- Reset asserted mid-operation discards all entries immediately; no issue completes.

Optional Feature:
- Macro LSQ_FLUSH_EN.
- When defined, adds input flush (1 bit). flush high at posedge:
  - invalidates all entries and sets head = tail = count = 0;
  - overrides any allocation or issue in that same cycle;
  - iss_valid = 0 from the following cycle.
- When undefined, the port does not exist and the queue clears only on rst.

Test Plan:
1. Reset then allocate load, tagx = UNLOCKED, datax = 0x1000, imm = 8 -> next cycle iss_valid = 1, iss_datax = 0x1000, iss_offset = 8, count = 1; iss_ready = 1 -> count = 0, iss_valid = 0.
2. Allocate store, tagx = 3, tagy = 5. Broadcast ch1 tag 3 data 0xAA, then ch2 tag 5 data 0xBB -> iss_valid = 1 exactly one cycle after the second broadcast, with iss_datax = 0xAA, iss_datay = 0xBB.
3. Allocate with alloc_tagx = 7 while cdb ch0 broadcasts tag 7 data 0x55 in the same cycle -> entry issues next cycle with iss_datax = 0x55.
4. Fill DEPTH = 4 entries with iss_ready = 0 -> alloc_ready = 0, count = 4. Assert alloc_valid and iss_ready together -> only issue occurs, count = 3. Then wrap tail past index 3 and check FIFO order is preserved.
5. Head blocked on tag 2, younger entry ready -> iss_valid stays 0. Broadcast tag 2 -> head issues first, then the younger entry.
6. With LSQ_FLUSH_EN and 3 entries queued, pulse flush together with alloc_valid -> count = 0, iss_valid = 0, alloc_ready = 1; the incoming op is dropped.
